// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: instruction fetch stage for the Hack CPU.
// Holds the fetch pointer, drives the synchronous instruction ROM, captures
// the returned word and presents it to decode with a valid/ready handshake.
// A jump presented together with an accepted instruction redirects the
// fetch pointer to the A-register target.
module hack_fetch_unit #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr
);

  // S_REQ: address is on the ROM port; S_CAP: ROM data arrives;
  // S_VALID: word held until the CPU takes it. Encoding 3 is unused.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_CAP   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_fpc;
  logic [ADDR_W-1:0]   w_fpc_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                r_valid;
  logic                w_valid_nxt;

  // Fetch pointer advance; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] fpc_inc(input logic [ADDR_W-1:0] a);
    fpc_inc = a + ADDR_W'(1);
  endfunction

  // Next-state and next-register values for the fetch sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    case (r_state)
      S_REQ: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_instr_nxt = rom_data;
        w_pc_nxt    = r_fpc;
        w_valid_nxt = 1'b1;
        w_fpc_nxt   = fpc_inc(r_fpc);
        w_state_nxt = S_VALID;
      end
      S_VALID: begin
        // jump only matters on the accepting edge; otherwise hold everything
        if (instr_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
          if (jump) begin
            w_fpc_nxt = jump_addr;
          end
        end
      end
      default: begin
        w_state_nxt = S_REQ;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over handshake and jump.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_REQ;
      r_fpc   <= '0;
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign rom_addr    = r_fpc;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb_hack_fetch_unit: directed per-cycle vector table for the fetch unit,
// with a behavioral synchronous ROM whose word at address a is a+1.
module tb_hack_fetch_unit;

  logic        CLK;
  logic        reset;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [14:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [14:0] jump_addr;

  int n_cmp;
  int n_bad;
  int hit55;

  hack_fetch_unit #(.ADDR_W(15), .DATA_W(16)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_addr   (jump_addr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous ROM: ROM[a] = a + 1, so ROM[0..3] = 1,2,3,4.
  always @(posedge CLK) begin
    rom_data <= {1'b0, rom_addr} + 16'h0001;
  end

  // The decoy jump target must never reach the ROM port.
  always @(posedge CLK) begin
    if (rom_addr == 15'h0055) hit55 = hit55 + 1;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic [14:0] ja;
    logic        v;
    logic [15:0] ins;
    logic [14:0] p;
    logic [14:0] ad;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rdy, input logic jmp,
                     input logic [14:0] ja, input logic v, input logic [15:0] ins,
                     input logic [14:0] p, input logic [14:0] ad);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.jmp = jmp; t.ja = ja;
    t.v = v; t.ins = ins; t.p = p; t.ad = ad;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    hit55 = 0;
    reset = 1'b1;
    instr_ready = 1'b0;
    jump = 1'b0;
    jump_addr = '0;

    //   rst rdy jmp ja        | v  instr    pc       rom_addr
    add(1, 0, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000); // 0 reset
    add(0, 1, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000); // REQ
    add(0, 1, 0, 15'h0000,     1, 16'h0001, 15'h0000, 15'h0001); // CAP ROM[0]
    add(0, 1, 0, 15'h0000,     0, 16'h0001, 15'h0000, 15'h0001); // accept
    add(0, 1, 0, 15'h0000,     0, 16'h0001, 15'h0000, 15'h0001);
    add(0, 1, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002); // 5 ROM[1]
    add(0, 1, 0, 15'h0000,     0, 16'h0002, 15'h0001, 15'h0002);
    add(0, 1, 0, 15'h0000,     0, 16'h0002, 15'h0001, 15'h0002);
    add(0, 1, 0, 15'h0000,     1, 16'h0003, 15'h0002, 15'h0003); // ROM[2]
    add(0, 1, 0, 15'h0000,     0, 16'h0003, 15'h0002, 15'h0003);
    add(0, 1, 0, 15'h0000,     0, 16'h0003, 15'h0002, 15'h0003); // 10
    add(0, 1, 0, 15'h0000,     1, 16'h0004, 15'h0003, 15'h0004); // ROM[3]
    add(0, 1, 1, 15'h0100,     0, 16'h0004, 15'h0003, 15'h0100); // jump accepted
    add(0, 1, 0, 15'h0000,     0, 16'h0004, 15'h0003, 15'h0100);
    add(0, 1, 0, 15'h0000,     1, 16'h0101, 15'h0100, 15'h0101); // target valid
    add(0, 0, 1, 15'h0055,     1, 16'h0101, 15'h0100, 15'h0101); // 15 jump, no ready
    add(0, 1, 0, 15'h0000,     0, 16'h0101, 15'h0100, 15'h0101);
    add(0, 1, 1, 15'h0055,     0, 16'h0101, 15'h0100, 15'h0101); // jump in REQ
    add(0, 1, 1, 15'h0055,     1, 16'h0102, 15'h0101, 15'h0102); // jump in CAP
    add(0, 1, 1, 15'h7FFF,     0, 16'h0102, 15'h0101, 15'h7FFF); // jump to top
    add(0, 1, 0, 15'h0000,     0, 16'h0102, 15'h0101, 15'h7FFF); // 20
    add(0, 1, 0, 15'h0000,     1, 16'h8000, 15'h7FFF, 15'h0000); // wrap
    add(0, 1, 0, 15'h0000,     0, 16'h8000, 15'h7FFF, 15'h0000);
    add(0, 1, 0, 15'h0000,     0, 16'h8000, 15'h7FFF, 15'h0000);
    add(0, 0, 0, 15'h0000,     1, 16'h0001, 15'h0000, 15'h0001); // pc 0 after wrap
    add(0, 0, 0, 15'h0000,     1, 16'h0001, 15'h0000, 15'h0001); // 25 hold
    add(1, 0, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000); // reset in VALID
    add(0, 0, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000);
    add(0, 0, 0, 15'h0000,     1, 16'h0001, 15'h0000, 15'h0001); // restart at 0
    add(0, 1, 0, 15'h0000,     0, 16'h0001, 15'h0000, 15'h0001);
    add(0, 1, 0, 15'h0000,     0, 16'h0001, 15'h0000, 15'h0001); // 30
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002); // ROM[1]
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002); // backpressure x5
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002);
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002);
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002); // 35
    add(0, 0, 0, 15'h0000,     1, 16'h0002, 15'h0001, 15'h0002);
    add(0, 1, 0, 15'h0000,     0, 16'h0002, 15'h0001, 15'h0002); // release
    add(0, 1, 0, 15'h0000,     0, 16'h0002, 15'h0001, 15'h0002);
    add(0, 1, 0, 15'h0000,     1, 16'h0003, 15'h0002, 15'h0003); // fetch addr 2
    add(0, 1, 0, 15'h0000,     0, 16'h0003, 15'h0002, 15'h0003); // 40
    add(0, 1, 0, 15'h0000,     0, 16'h0003, 15'h0002, 15'h0003);
    add(1, 1, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000); // reset in CAP
    add(0, 1, 0, 15'h0000,     0, 16'h0000, 15'h0000, 15'h0000);
    add(0, 1, 0, 15'h0000,     1, 16'h0001, 15'h0000, 15'h0001); // restart at 0
    add(0, 1, 0, 15'h0000,     0, 16'h0001, 15'h0000, 15'h0001); // 45

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      reset       = tbl[i].rst;
      instr_ready = tbl[i].rdy;
      jump        = tbl[i].jmp;
      jump_addr   = tbl[i].ja;
      @(posedge CLK);
      #1;
      chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, tbl[i].v});
      chk("instr",       i, {16'd0, instr},       {16'd0, tbl[i].ins});
      chk("pc",          i, {17'd0, pc},          {17'd0, tbl[i].p});
      chk("rom_addr",    i, {17'd0, rom_addr},    {17'd0, tbl[i].ad});
    end

    // First-fetch latency after reset release, with a bounded wait.
    @(negedge CLK);
    reset = 1'b1;
    instr_ready = 1'b1;
    jump = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin
      @(posedge CLK);
      #1;
      n = n + 1;
    end
    chk("first_valid_edges", 100, n, 2);
    chk("first_instr", 100, {16'd0, instr}, 32'h0001);
    chk("first_pc", 100, {17'd0, pc}, 32'h0000);
    @(posedge CLK);
    #1;
    chk("valid_one_cycle", 101, {31'd0, instr_valid}, 32'd0);

    chk("rom_addr_never_0x55", 102, hit55, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_fetch_unit.md
# hack_fetch_unit

Instruction fetch stage for the Hack CPU. It holds the program counter, drives the instruction ROM address, captures the returned word into a 16-bit instruction holding register, and presents it to the CPU decode/execute stage with a valid/ready handshake. Jumps from the CPU (A-register target) redirect the fetch pointer. It sits between the instruction ROM and the CPU, directly upstream of the A/D/instruction registers.

## Interface
- `ADDR_W`, default 15: ROM address / PC width.
- `DATA_W`, default 16: instruction width.
- `CLK` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on `CLK` rising edge.
- `rom_addr` output ADDR_W: address presented to the synchronous instruction ROM; equals internal fetch pointer `fpc`.
- `rom_data` input DATA_W: ROM read data; valid one cycle after `rom_addr` is sampled by the ROM.
- `instr` output DATA_W: held instruction word.
- `pc` output ADDR_W: address from which `instr` was fetched.
- `instr_valid` output 1: `instr` and `pc` are valid.
- `instr_ready` input 1: CPU accepts `instr` this cycle.
- `jump` input 1: CPU requests redirect; qualified by the handshake.
- `jump_addr` input ADDR_W: redirect target.

## Operation
- Registers: `fpc`, `instr`, `pc`, `instr_valid`, 2-bit `state`.
- Reset values: `fpc`=0, hence `rom_addr`=0; `instr`=0; `pc`=0; `instr_valid`=0; `state`=S_REQ.
- S_REQ: `rom_addr`=`fpc` is held for the ROM to sample. Next state is S_CAP unconditionally.
- S_CAP: on the edge, latch `instr`<=`rom_data` and `pc`<=`fpc`; set `instr_valid`<=1; set `fpc`<=`fpc`+1 (modulo 2^ADDR_W). Next state is S_VALID.
- S_VALID: `instr`, `pc` and `instr_valid` are held stable while `instr_ready`=0.
  - If `instr_ready`=1 and `jump`=0: clear `instr_valid`; `fpc` is unchanged (already incremented); go to S_REQ.
  - If `instr_ready`=1 and `jump`=1: set `fpc`<=`jump_addr`; clear `instr_valid`; go to S_REQ.
- `jump` is honored only in S_VALID with `instr_ready`=1. In every other cycle it is ignored and has no side effect.
- Wrap-around: `fpc`=0x7FFF increments to 0x0000. No overflow flag.
- Illegal state encoding (3): next state is S_REQ with `instr_valid`=0.
- Reset mid-operation: an in-flight ROM read is discarded, a held instruction is dropped, and all registers return to reset values. Reset has priority over the handshake and `jump`.

## Timing
- Reset sampled high at edge E0. At E1, `rom_addr`=0 is sampled by the ROM. At E2, `instr`=ROM[0] and `instr_valid`=1.
- Fetch latency is 2 cycles from entering S_REQ to `instr_valid`=1.
- Minimum issue interval is 3 cycles per instruction (S_REQ, S_CAP, S_VALID with ready).
- Handshake completes on the edge where `instr_valid`=1 and `instr_ready`=1. `instr_valid` drops on that same edge.
- `instr_ready` while `instr_valid`=0 is ignored.
- Jump latency: accepted at edge Ej, `rom_addr`=`jump_addr` in the following cycle, and the target instruction is valid at Ej+2.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset then free-run with ROM[0..3]=0x0001,0x0002,0x0003,0x0004 and `instr_ready`=1 -> `instr`/`pc` pairs (0x0001,0),(0x0002,1),(0x0003,2),(0x0004,3) each valid for exactly 1 cycle, spaced 3 cycles apart, with the first valid 2 edges after reset release.
- Backpressure: hold `instr_ready`=0 for 5 cycles while `instr`=ROM[1] -> `instr`, `pc`=1 and `instr_valid`=1 stay stable and `rom_addr` stays 2. On release, the next fetch is address 2.
- Jump: `jump`=1, `jump_addr`=0x0100, `instr_ready`=1 while `pc`=3 -> next `rom_addr`=0x0100, next `pc`=0x0100, and address 4 is never presented as valid.
- Unqualified jump: pulse `jump`=1 with `jump_addr`=0x0055 during S_REQ and S_CAP, and during S_VALID with `instr_ready`=0 -> sequence unaffected and `rom_addr` never 0x0055.
- Wrap: jump to 0x7FFF, accept -> `pc`=0x7FFF, then next `pc`=0x0000.
- Reset mid-operation: assert `reset` during S_CAP and during S_VALID with `instr_ready`=0 -> the following cycle shows `instr_valid`=0, `instr`=0, `pc`=0, `rom_addr`=0, and fetch restarts from address 0.
